// File: rtl/change_dispenser.sv
// Change dispenser: converts a BCD change amount into nickels and pays it out
// greedily from quarter/dime/nickel hoppers, one acknowledged coin at a time.
module change_dispenser #(
  parameter int         PULSE_CYCLES = 4,
  parameter int         GAP_CYCLES   = 2,
  parameter logic [7:0] TIMEOUT      = 8'd255
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       change_valid,
  input  logic [7:0] change_amt,
  output logic       change_ready,
  input  logic [2:0] hopper_empty,
  input  logic       hopper_ack,
  output logic [2:0] coin_eject,
  output logic [7:0] remaining,
  output logic       done,
  output logic       error
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] SELECT   = 3'd1;
  localparam logic [2:0] EJECT    = 3'd2;
  localparam logic [2:0] WAIT_ACK = 3'd3;
  localparam logic [2:0] GAP      = 3'd4;
  localparam logic [2:0] DONE     = 3'd5;
  localparam logic [2:0] FAULT    = 3'd6;

  localparam logic [7:0] PULSE_LAST = 8'(PULSE_CYCLES - 1);
  localparam logic [7:0] GAP_LAST   = 8'(GAP_CYCLES - 1);
  localparam logic [7:0] TMO_LAST   = TIMEOUT - 8'd1;

  logic [2:0] state_r, state_s;
  logic [7:0] cnt_r, cnt_s;
  logic [4:0] nick_r, nick_s;
  logic [2:0] denom_r, denom_s;
  logic       error_r, error_s;
  logic       ready_r, done_r;
  logic [2:0] coin_eject_r;
  logic [7:0] remaining_r;
  logic       accept_s;

  function automatic logic amt_legal(input logic [7:0] amt);
    return (amt[7:4] <= 4'd9) && ((amt[3:0] == 4'd0) || (amt[3:0] == 4'd5));
  endfunction

  function automatic logic [4:0] to_nick(input logic [7:0] amt);
    return {amt[7:4], 1'b0} + {4'b0000, (amt[3:0] == 4'd5)};
  endfunction

  // n nickels = n*5 cents, so tens = n/2 and ones = 5 when n is odd
  function automatic logic [7:0] to_bcd(input logic [4:0] n);
    return {n[4:1], (n[0] ? 4'd5 : 4'd0)};
  endfunction

  function automatic logic [4:0] denom_val(input logic [2:0] d);
    case (d)
      3'b001:  return 5'd1;
      3'b010:  return 5'd2;
      3'b100:  return 5'd5;
      default: return 5'd0;
    endcase
  endfunction

  assign accept_s = change_valid & ready_r;

  // Next-state, counter, coin-count and error computation
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    nick_s  = nick_r;
    denom_s = denom_r;
    error_s = error_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          error_s = 1'b0;
          cnt_s   = 8'd0;
          if (!amt_legal(change_amt)) begin
            nick_s  = 5'd0;
            state_s = FAULT;
          end else begin
            nick_s  = to_nick(change_amt);
            state_s = (to_nick(change_amt) == 5'd0) ? DONE : SELECT;
          end
        end else begin
          state_s = IDLE;
        end
      end
      SELECT: begin
        cnt_s = 8'd0;
        if ((nick_r >= 5'd5) && !hopper_empty[2]) begin
          denom_s = 3'b100;
          state_s = EJECT;
        end else if ((nick_r >= 5'd2) && !hopper_empty[1]) begin
          denom_s = 3'b010;
          state_s = EJECT;
        end else if ((nick_r >= 5'd1) && !hopper_empty[0]) begin
          denom_s = 3'b001;
          state_s = EJECT;
        end else begin
          state_s = FAULT;
        end
      end
      EJECT: begin
        if (cnt_r == PULSE_LAST) begin
          cnt_s   = 8'd0;
          state_s = WAIT_ACK;
        end else begin
          cnt_s = cnt_r + 8'd1;
        end
      end
      WAIT_ACK: begin
        // an ack in the final waiting cycle still beats the timeout
        if (hopper_ack) begin
          nick_s  = nick_r - denom_val(denom_r);
          cnt_s   = 8'd0;
          state_s = (nick_s == 5'd0) ? DONE : GAP;
        end else if (cnt_r == TMO_LAST) begin
          cnt_s   = 8'd0;
          state_s = FAULT;
        end else begin
          cnt_s = cnt_r + 8'd1;
        end
      end
      GAP: begin
        if (cnt_r == GAP_LAST) begin
          cnt_s   = 8'd0;
          state_s = SELECT;
        end else begin
          cnt_s = cnt_r + 8'd1;
        end
      end
      DONE:    state_s = IDLE;
      FAULT:   state_s = IDLE;
      default: state_s = IDLE;
    endcase
    if (state_s == FAULT) begin
      error_s = 1'b1;
    end else begin
      error_s = error_s;
    end
  end

  // State and registered output update
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= IDLE;
      cnt_r        <= 8'd0;
      nick_r       <= 5'd0;
      denom_r      <= 3'b000;
      error_r      <= 1'b0;
      ready_r      <= 1'b1;
      done_r       <= 1'b0;
      coin_eject_r <= 3'b000;
      remaining_r  <= 8'h00;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      nick_r       <= nick_s;
      denom_r      <= denom_s;
      error_r      <= error_s;
      ready_r      <= (state_s == IDLE);
      done_r       <= (state_s == DONE) || (state_s == FAULT);
      coin_eject_r <= (state_s == EJECT) ? denom_s : 3'b000;
      remaining_r  <= to_bcd(nick_s);
    end
  end

  assign change_ready = ready_r;
  assign coin_eject   = coin_eject_r;
  assign remaining    = remaining_r;
  assign done         = done_r;
  assign error        = error_r;

endmodule

// File: doc/change_dispenser.md
# change_dispenser

Pays out change owed after a vending transaction by ejecting coins one at a time from three coin hoppers (nickel, dime, quarter). Accepts a BCD change amount from the vending controller using the same cent encoding as its `left_display` (8'h05 = 5 cents), then computes coins greedily. Drives one-hot coin-eject pulses using the same encoding as the vending machine's `coin` input, and waits for a hopper drop acknowledge after each coin. Sits between the vending controller and the coin-hopper drivers.

## Interface
- `PULSE_CYCLES`, 4: cycles each coin_eject pulse is held high (≥1).
- `GAP_CYCLES`, 2: idle cycles between consecutive coins (≥1).
- `TIMEOUT`, 8'd255: max cycles to wait for hopper_ack after a pulse ends (1..255).

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset_n`  in  1  reset; **one clock; reset is asynchronous and active-low**.
- `change_valid`  in  1  change request; held by requester until accepted.
- `change_amt`  in  8  BCD cents; legal values: tens 0–9, ones 0 or 5.
- `change_ready`  out  1  high only in IDLE; accept = valid & ready at clock edge.
- `hopper_empty`  in  3  per-denomination empty flags: [0] nickel, [1] dime, [2] quarter.
- `hopper_ack`  in  1  one-cycle pulse from hopper: coin dropped.
- `coin_eject`  out  3  one-hot eject: 3'b001 nickel, 3'b010 dime, 3'b100 quarter.
- `remaining`  out  8  BCD cents still owed.
- `done`  out  1  one-cycle pulse at end of every accepted request.
- `error`  out  1  set with a faulting done; held until next accept.

## Operation
- States: IDLE, SELECT, EJECT, WAIT_ACK, GAP, DONE, FAULT.
- **Accept in IDLE:** latch change_amt and convert to a 5-bit nickel count n = (10·tens + ones)/5, max 19.
  - Clear error.
  - Next state:
    - illegal BCD → FAULT
    - n = 0 → DONE
    - otherwise → SELECT
- **SELECT:** pick the largest denomination whose value ≤ remaining and whose hopper_empty bit is 0 (quarter = 5 nickels, dime = 2, nickel = 1).
  - None available → FAULT.
  - Otherwise latch the denomination → EJECT.
- **EJECT:** coin_eject = latched one-hot for exactly PULSE_CYCLES cycles → WAIT_ACK.
- **WAIT_ACK:** timeout counter increments each cycle.
  - hopper_ack: subtract the denomination from the nickel count.
    - Result 0 → DONE.
    - Otherwise → GAP.
  - Counter reaches TIMEOUT without ack → FAULT, with no subtraction.
- **GAP:** GAP_CYCLES cycles with coin_eject = 0 → SELECT.
  - hopper_empty is re-evaluated at each SELECT.
- **DONE:** done = 1 for one cycle → IDLE.
- **FAULT:** done = 1 and error set for one cycle → IDLE.
  - error then stays 1 until the next accept.
  - remaining keeps the unpaid amount.
- **remaining:** BCD re-encoding of the nickel count, updated the cycle after each subtraction.
- **Ignored inputs:** hopper_ack outside WAIT_ACK; change_valid while change_ready = 0.

## Timing
- **Reset (reset_n low), asynchronous:**
  - State IDLE.
  - coin_eject = 3'b000, done = 0, error = 0, remaining = 8'h00, change_ready = 1.
  - All counters 0.
- **Reset mid-operation:**
  - coin_eject drops immediately.
  - The request is abandoned; no resumption after release.
- **Outputs:** all decoded from registered state/counters; no combinational input → output path.
- **Latency:**
  - Accept at edge k: SELECT during cycle k+1; coin_eject high cycles k+2 … k+1+PULSE_CYCLES.
  - Ack in cycle j: remaining updates at j+1; next coin's EJECT starts at j+2+GAP_CYCLES.
  - Final ack in cycle j: done high in cycle j+1; change_ready high at j+2.
- **Zero amount:** done in cycle k+1, no eject.
- **Illegal amount:** done and error in cycle k+1, no eject.
- **Timeout:** FAULT occurs TIMEOUT cycles after EJECT ends.
- **Ack on the same edge as timeout:** the ack wins.

## Test plan
- change_amt 8'h20, hoppers full, ack 3 cycles after each pulse → two 3'b010 pulses of 4 cycles each; remaining 20→10→00; done once; error 0.
- change_amt 8'h40 → pulse sequence 100, 010, 001; remaining 40→15→05→00; done with error 0.
- change_amt 8'h15 with hopper_empty = 3'b010 → three 3'b001 pulses; then raise hopper_empty[0] after the first ack → FAULT with remaining 8'h10 and error 1.
- change_amt 8'h07, then 8'h00 → 8'h07 gives done and error at k+1 with no eject; 8'h00 gives done with error 0 and no eject.
- change_amt 8'h05 with hopper_ack never asserted → FAULT exactly 255 cycles after the pulse ends; remaining 8'h05; next request clears error.
- reset_n low during EJECT of 8'h25 → coin_eject 0 immediately; after release, change_ready 1, remaining 00, no further pulses; change_valid during busy is not accepted.
